// File: rtl/param_data_memory_pkg.sv
// rtl/param_data_memory_pkg.sv - shared state encoding and width helper for the data memory
package param_mem_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    READ_WAIT
  } mem_state_e;

  // Ceiling log2; loop bound keeps it a constant-foldable function for elaboration.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/param_data_memory_if.sv
// rtl/param_data_memory_if.sv - request/response bus between a requester and the data memory
interface param_data_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    ReqValid;
  logic                    ReqReady;
  logic                    MemRead;
  logic                    MemWrite;
  logic [ADDR_WIDTH-1:0]   Address;
  logic [DATA_WIDTH-1:0]   WriteData;
  logic [DATA_WIDTH/8-1:0] ByteEn;
  logic                    RespValid;
  logic [DATA_WIDTH-1:0]   ReadData;
  logic                    Error;
  logic                    InitDone;

  modport master (
    output ReqValid, MemRead, MemWrite, Address, WriteData, ByteEn,
    input  ReqReady, RespValid, ReadData, Error, InitDone
  );

  modport slave (
    input  ReqValid, MemRead, MemWrite, Address, WriteData, ByteEn,
    output ReqReady, RespValid, ReadData, Error, InitDone
  );
endinterface

// File: rtl/param_mem_array.sv
// rtl/param_mem_array.sv - word storage with one byte-enabled write port and one registered read port
module param_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic                    re,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Storage itself is not reset; the controller clears it word by word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/param_data_memory.sv
// rtl/param_data_memory.sv - self-clearing word memory with a request/response bus and
// configurable read latency
module param_data_memory
  import param_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  param_data_memory_if.slave bus
);
  localparam int IDX_W  = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int LAT_W  = clog2(READ_LATENCY + 1);
  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int WIDX_W = ADDR_WIDTH - 2;

  mem_state_e            state_q, state_d;
  logic [IDX_W-1:0]      clr_idx_q, clr_idx_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

  logic [WIDX_W-1:0]     word_idx;
  logic                  req_ok;
  logic                  rd_resp;
  logic                  arr_we;
  logic [IDX_W-1:0]      arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [BE_W-1:0]       arr_wbe;
  logic                  arr_re;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign word_idx = bus.Address[ADDR_WIDTH-1:2];
  assign req_ok   = (bus.MemRead ^ bus.MemWrite) && (bus.Address[1:0] == 2'b00) &&
                    (word_idx < WIDX_W'(DEPTH));
  // Last READ_WAIT cycle: the sampled word is presented and latched as the held result.
  assign rd_resp  = (state_q == READ_WAIT) && (lat_cnt_q == LAT_W'(READ_LATENCY));

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    lat_cnt_d    = lat_cnt_q;
    init_done_d  = init_done_q;
    resp_valid_d = 1'b0;
    error_d      = 1'b0;
    read_data_d  = rd_resp ? arr_rdata : read_data_q;
    arr_we       = 1'b0;
    arr_waddr    = word_idx[IDX_W-1:0];
    arr_wdata    = bus.WriteData;
    arr_wbe      = bus.ByteEn;
    arr_re       = 1'b0;
    case (state_q)
      INIT: begin
        arr_we    = 1'b1;
        arr_waddr = clr_idx_q;
        arr_wdata = '0;
        arr_wbe   = '1;
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
          clr_idx_d   = '0;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      IDLE: begin
        if (bus.ReqValid) begin
          resp_valid_d = 1'b1;
          if (!req_ok) begin
            error_d = 1'b1;
          end else if (bus.MemWrite) begin
            arr_we = 1'b1;
          end else begin
            arr_re       = 1'b1;
            lat_cnt_d    = LAT_W'(1);
            state_d      = READ_WAIT;
            resp_valid_d = (READ_LATENCY == 1);
          end
        end
      end
      READ_WAIT: begin
        if (rd_resp) begin
          state_d   = IDLE;
          lat_cnt_d = '0;
        end else begin
          lat_cnt_d    = lat_cnt_q + LAT_W'(1);
          resp_valid_d = (lat_cnt_q == LAT_W'(READ_LATENCY - 1));
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= INIT;
      clr_idx_q    <= '0;
      lat_cnt_q    <= '0;
      init_done_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      error_q      <= 1'b0;
      read_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      lat_cnt_q    <= lat_cnt_d;
      init_done_q  <= init_done_d;
      resp_valid_q <= resp_valid_d;
      error_q      <= error_d;
      read_data_q  <= read_data_d;
    end
  end

  param_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk  (Clk),
    .rst  (Reset),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .wbe  (arr_wbe),
    .re   (arr_re),
    .raddr(word_idx[IDX_W-1:0]),
    .rdata(arr_rdata)
  );

  assign bus.ReqReady  = (state_q == IDLE);
  assign bus.RespValid = resp_valid_q;
  assign bus.Error     = error_q;
  assign bus.ReadData  = read_data_d;
  assign bus.InitDone  = init_done_q;
endmodule

// File: tb/tb_param_data_memory.sv
// tb/tb_param_data_memory.sv - directed vector bench driving latency-1 and latency-3 instances
// with identical stimulus
module tb_param_data_memory;
  logic        Clk;
  logic        Reset;
  logic        req_valid, mem_read, mem_write;
  logic [31:0] address, write_data;
  logic [3:0]  byte_en;
  int          checks, failures;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[13];
  vec_t v;

  param_data_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();
  param_data_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus3 ();

  assign bus1.ReqValid  = req_valid;
  assign bus1.MemRead   = mem_read;
  assign bus1.MemWrite  = mem_write;
  assign bus1.Address   = address;
  assign bus1.WriteData = write_data;
  assign bus1.ByteEn    = byte_en;
  assign bus3.ReqValid  = req_valid;
  assign bus3.MemRead   = mem_read;
  assign bus3.MemWrite  = mem_write;
  assign bus3.Address   = address;
  assign bus3.WriteData = write_data;
  assign bus3.ByteEn    = byte_en;

  param_data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .READ_LATENCY(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .bus(bus1.slave));
  param_data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .READ_LATENCY(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .bus(bus3.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  // Applies one request and checks both instances through their full response windows.
  task automatic run_vec(input vec_t tv, input int idx);
    int guard;
    guard = 0;
    while (!(bus1.ReqReady && bus3.ReqReady) && guard < 20) begin
      @(posedge Clk); #1;
      guard++;
    end
    chk("ready_before", idx, {bus1.ReqReady, bus3.ReqReady}, 2'b11);
    mem_read = tv.rd; mem_write = tv.wr; address = tv.addr;
    write_data = tv.wd; byte_en = tv.be; req_valid = 1'b1;
    @(posedge Clk); #1;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge Clk);
    chk("resp1", idx, bus1.RespValid, 1'b1);
    chk("err1", idx, bus1.Error, tv.exp_err);
    chk("rdata1", idx, bus1.ReadData, tv.exp_rd);
    if (tv.rd && !tv.wr && !tv.exp_err) begin
      chk("resp3_c1", idx, {bus3.RespValid, bus3.ReqReady}, 2'b00);
      @(negedge Clk);
      chk("resp1_pulse", idx, {bus1.RespValid, bus1.ReqReady}, 2'b01);
      chk("resp3_c2", idx, {bus3.RespValid, bus3.ReqReady}, 2'b00);
      @(negedge Clk);
      chk("resp3_c3", idx, {bus3.RespValid, bus3.Error, bus3.ReqReady}, 3'b100);
      chk("rdata3", idx, bus3.ReadData, tv.exp_rd);
      @(posedge Clk); #1;
      chk("ready3_back", idx, {bus3.RespValid, bus3.ReqReady}, 2'b01);
    end else begin
      chk("resp3", idx, {bus3.RespValid, bus3.Error}, {1'b1, tv.exp_err});
      chk("rdata3", idx, bus3.ReadData, tv.exp_rd);
      @(posedge Clk); #1;
      chk("resp1_pulse", idx, {bus1.RespValid, bus3.RespValid}, 2'b00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    logic seen_resp;
    checks = 0; failures = 0;
    vecs[0]  = '{1'b1, 1'b0, 32'h14,  32'h0,        4'h0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h10,  32'h00000011, 4'h1, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADBE11};
    vecs[4]  = '{1'b1, 1'b0, 32'h13,  32'h0,        4'h0, 1'b1, 32'hDEADBE11};
    vecs[5]  = '{1'b1, 1'b0, 32'h100, 32'h0,        4'h0, 1'b1, 32'hDEADBE11};
    vecs[6]  = '{1'b1, 1'b1, 32'h10,  32'h0,        4'hF, 1'b1, 32'hDEADBE11};
    vecs[7]  = '{1'b0, 1'b0, 32'h10,  32'h0,        4'hF, 1'b1, 32'hDEADBE11};
    vecs[8]  = '{1'b0, 1'b1, 32'hFC,  32'hA5A5A5A5, 4'hA, 1'b0, 32'hDEADBE11};
    vecs[9]  = '{1'b1, 1'b0, 32'hFC,  32'h0,        4'h0, 1'b0, 32'hA500A500};
    vecs[10] = '{1'b1, 1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADBE11};
    vecs[11] = '{1'b0, 1'b1, 32'h12,  32'hFFFFFFFF, 4'hF, 1'b1, 32'hDEADBE11};
    vecs[12] = '{1'b1, 1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADBE11};

    Reset = 1'b1; req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    address = 32'h14; write_data = 32'h0; byte_en = 4'h0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset_ctl1", 0, {bus1.ReqReady, bus1.RespValid, bus1.Error, bus1.InitDone}, 4'b0000);
    chk("reset_ctl3", 0, {bus3.ReqReady, bus3.RespValid, bus3.Error, bus3.InitDone}, 4'b0000);
    chk("reset_rdata1", 0, bus1.ReadData, 32'h0);
    chk("reset_rdata3", 0, bus3.ReadData, 32'h0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge Clk);
      chk("init_busy", i, {bus1.ReqReady, bus1.InitDone, bus3.ReqReady, bus3.InitDone}, 4'b0000);
    end
    @(negedge Clk);
    chk("init_done", 0, {bus1.ReqReady, bus1.InitDone, bus3.ReqReady, bus3.InitDone}, 4'b1111);
    req_valid = 1'b0; mem_read = 1'b0;
    @(posedge Clk); #1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Back-to-back writes: ReqValid held high across two acceptance edges.
    address = 32'h20; write_data = 32'h12345678; byte_en = 4'hF;
    mem_write = 1'b1; req_valid = 1'b1;
    @(posedge Clk); #1;
    chk("b2b_ready", 0, {bus1.ReqReady, bus3.ReqReady}, 2'b11);
    address = 32'h24; write_data = 32'h9ABCDEF0;
    @(negedge Clk);
    chk("b2b_resp", 0, {bus1.RespValid, bus1.Error, bus3.RespValid, bus3.Error}, 4'b1010);
    @(posedge Clk); #1;
    req_valid = 1'b0; mem_write = 1'b0;
    @(negedge Clk);
    chk("b2b_resp", 1, {bus1.RespValid, bus1.Error, bus3.RespValid, bus3.Error}, 4'b1010);
    @(posedge Clk); #1;
    v = '{1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h12345678};
    run_vec(v, 100);
    v = '{1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0, 32'h9ABCDEF0};
    run_vec(v, 101);

    // Reset while the latency-3 instance sits in READ_WAIT.
    mem_read = 1'b1; address = 32'h10; req_valid = 1'b1;
    @(posedge Clk); #1;
    req_valid = 1'b0; mem_read = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    chk("mid_reset", 0, {bus1.RespValid, bus3.RespValid, bus1.InitDone, bus3.InitDone}, 4'b0000);
    @(posedge Clk); #1;
    Reset = 1'b0;
    guard = 0; seen_resp = 1'b0;
    while (!(bus1.InitDone && bus3.InitDone) && guard < 200) begin
      @(posedge Clk); #1;
      if (bus1.RespValid || bus3.RespValid) seen_resp = 1'b1;
      guard++;
    end
    chk("reinit_done", 0, {bus1.InitDone, bus3.InitDone}, 2'b11);
    chk("reinit_no_resp", 0, seen_resp, 1'b0);
    v = '{1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0};
    run_vec(v, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 Parameter DATA_WIDTH, 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, 32, byte-address width.
REQ-003 Parameter DEPTH, 64, number of words stored.
REQ-004 Parameter READ_LATENCY, 1, cycles from read acceptance to response; legal range 1..8.
REQ-005 Clk  input  1  single clock; all state changes on posedge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 ReqValid  input  1  request present.
REQ-008 ReqReady  output  1  block can accept a request this cycle.
REQ-009 MemRead  input  1  request is a read.
REQ-010 MemWrite  input  1  request is a write.
REQ-011 Address  input  ADDR_WIDTH  byte address; word index = Address[ADDR_WIDTH-1:2].
REQ-012 WriteData  input  DATA_WIDTH  write data.
REQ-013 ByteEn  input  DATA_WIDTH/8  per-byte write enable.
REQ-014 RespValid  output  1  one-cycle response pulse.
REQ-015 ReadData  output  DATA_WIDTH  read result; holds until next successful read.
REQ-016 Error  output  1  qualifies RespValid; 1 = request rejected.
REQ-017 InitDone  output  1  memory clear complete.

Function
REQ-018 States SHALL be INIT, IDLE, READ_WAIT.
REQ-019 INIT: clear one word per cycle, index 0..DEPTH-1; ReqReady=0; ReqValid ignored; after word DEPTH-1 cleared, go to IDLE and set InitDone=1 (held until reset).
REQ-020 Handshake: request accepted at a posedge where ReqValid=1 and ReqReady=1; ReqReady=1 only in IDLE.
REQ-021 Invalid request (MemRead=MemWrite, Address[1:0]!=0, or word index >= DEPTH): no memory access; RespValid=1, Error=1 in the cycle after acceptance; ReadData unchanged; state stays IDLE.
REQ-022 Valid write: bytes with ByteEn=1 updated at the acceptance edge, others preserved; RespValid=1, Error=0 next cycle; state stays IDLE (back-to-back writes at one per cycle).
REQ-023 Valid read: word sampled at acceptance edge; go to READ_WAIT; RespValid=1, Error=0, ReadData=word exactly READ_LATENCY cycles after acceptance.
REQ-024 READ_WAIT: ReqReady=0 through the RespValid cycle inclusive; return to IDLE at the edge ending that cycle.
REQ-025 A read following a write to the same word SHALL return the written data.
REQ-026 Latency counter width SHALL be clog2(READ_LATENCY+1); no wrap-around permitted.

Reset
REQ-027 Reset asserted: immediately state=INIT, clear index=0, ReqReady=0, RespValid=0, Error=0, ReadData=0, InitDone=0.
REQ-028 Reset during READ_WAIT or INIT SHALL abort the operation; no response issued; full clear restarts.

Structure
REQ-029 Package param_mem_pkg SHALL hold the state enum and clog2 helper function.
REQ-030 Storage SHALL be sub-module param_mem_array: DEPTH x DATA_WIDTH, one byte-enabled write port, one registered read port.

Verification
REQ-031 Reset, hold ReqValid=1 -> ReqReady=0 and InitDone=0 for DEPTH cycles, then InitDone=1, ReqReady=1; read of index 5 returns 0.
REQ-032 Write 0xDEADBEEF @0x10, ByteEn=4'b1111; then write 0x00000011 ByteEn=4'b0001; read 0x10 -> ReadData=0xDEADBE11, Error=0.
REQ-033 READ_LATENCY=3: read accepted at edge N -> RespValid high only in cycle after edge N+2; ReqReady=0 until edge N+3.
REQ-034 Read @0x13 (misaligned), @DEPTH*4 (out of range), MemRead=MemWrite=1 -> each RespValid=1, Error=1 next cycle, memory and ReadData unchanged.
REQ-035 Reset asserted mid-READ_WAIT -> no RespValid, InitDone=0, previously written word reads 0 after re-init.
